// File: rtl/shift_right_var.sv
// Variable-amount arithmetic right shifter: log2 barrel-shifter mux stack
// followed by one output register (1-cycle latency, one result per clock).
module shift_right_var #(
  parameter int WORD_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WORD_WIDTH-1:0]  data_in,
  input  logic [SHIFT_WIDTH-1:0] shift_amount,
  output logic                   out_valid,
  output logic [WORD_WIDTH-1:0]  data_out
);

  // Valid-only handshake: a beat is accepted on every edge where in_valid=1;
  // out_valid is high for exactly the cycle after an accepted beat, no backpressure.

  logic [WORD_WIDTH-1:0] stage_data [SHIFT_WIDTH+1];

  assign stage_data[0] = data_in;

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    localparam longint STEP = longint'(1) << k;
    logic [WORD_WIDTH-1:0] shifted;
    logic                  fill_bit;

    assign fill_bit = stage_data[k][WORD_WIDTH-1];

    // A stage whose step reaches the word width leaves only sign bits; never wrap.
    if (STEP >= longint'(WORD_WIDTH)) begin : g_sat
      assign shifted = {WORD_WIDTH{fill_bit}};
    end else begin : g_shift
      localparam int S = int'(STEP);
      assign shifted = {{S{fill_bit}}, stage_data[k][WORD_WIDTH-1:S]};
    end

    assign stage_data[k+1] = shift_amount[k] ? shifted : stage_data[k];
  end

  logic [WORD_WIDTH-1:0] data_out_q;
  logic [WORD_WIDTH-1:0] data_out_d;
  logic                  out_valid_q;
  logic                  out_valid_d;

  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      data_out_d = stage_data[SHIFT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shift_right_var.sv
// Self-checking bench for shift_right_var: directed scenarios plus randomized
// stimulus compared against a floor-division reference model.
module tb_shift_right_var;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  data_in;
  logic [3:0]    shift_amount;
  logic [4:0]    shift_amount_w;
  logic          out_valid;
  logic [W-1:0]  data_out;
  logic          out_valid_w;
  logic [W-1:0]  data_out_w;

  int checks;
  int passes;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w_q[$];

  shift_right_var #(.WORD_WIDTH(W), .SHIFT_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .out_valid    (out_valid),
    .data_out     (data_out)
  );

  // Wider shift port so amounts >= WORD_WIDTH can be exercised.
  shift_right_var #(.WORD_WIDTH(W), .SHIFT_WIDTH(5)) dut_wide (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .shift_amount (shift_amount_w),
    .out_valid    (out_valid_w),
    .data_out     (data_out_w)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s);
    longint a;
    longint p;
    longint r;
    a = longint'($signed(d));
    p = longint'(1) << s;
    if (a >= 0) r = a / p;
    else        r = -((-a + p - 1) / p);
    return r[W-1:0];
  endfunction

  // ---------------- driver ----------------
  // Apply inputs, then return 1 time unit after the capturing edge.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d,
                             input int sh, input int sh_w);
    in_valid       = v;
    data_in        = d;
    shift_amount   = 4'(sh);
    shift_amount_w = 5'(sh_w);
    if (v && !rst) begin
      exp_q.push_back(ref_shift(d, sh));
      exp_w_q.push_back(ref_shift(d, sh_w));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    rst = 1'b1;
    drive_cycle(1'b0, 16'h0, 0, 0);
    drive_cycle(1'b0, 16'h0, 0, 0);
    checks++;
    if (data_out !== 16'h0 || out_valid !== 1'b0)
      $display("FAIL reset_idle: data_out=%h out_valid=%b required 0000/0", data_out, out_valid);
    else passes++;
    rst = 1'b0;
    drive_cycle(1'b1, 16'd597, 3, 3);
    e = exp_q.pop_front();
    void'(exp_w_q.pop_front());
    checks++;
    if (data_out !== e || out_valid !== 1'b1)
      $display("FAIL reset_release: data_out=%h out_valid=%b required %h/1", data_out, out_valid, e);
    else passes++;
    rst = 1'b1;
    drive_cycle(1'b1, 16'h1234, 2, 2);
    checks++;
    if (data_out !== 16'h0 || out_valid !== 1'b0)
      $display("FAIL reset_priority: data_out=%h out_valid=%b required 0000/0", data_out, out_valid);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic run_directed(input string name, input logic [W-1:0] d,
                              input int sh, input logic [W-1:0] literal_exp);
    logic [W-1:0] e;
    drive_cycle(1'b1, d, sh, sh);
    e = exp_q.pop_front();
    void'(exp_w_q.pop_front());
    checks++;
    if (data_out !== literal_exp || e !== literal_exp || out_valid !== 1'b1)
      $display("FAIL %s: data_out=%h out_valid=%b model=%h required %h/1",
               name, data_out, out_valid, e, literal_exp);
    else passes++;
  endtask

  task automatic test_basic();
    run_directed("basic_597_3",  16'd597, 3, 16'd74);
    run_directed("basic_597_1",  16'd597, 1, 16'd298);
    run_directed("basic_16_2",   16'd16,  2, 16'd4);
  endtask

  task automatic test_sign_fill();
    run_directed("sign_m597_3",  16'hFDAB, 3,  16'hFFB5);
    run_directed("sign_m1_15",   16'hFFFF, 15, 16'hFFFF);
    run_directed("sign_min_15",  16'h8000, 15, 16'hFFFF);
  endtask

  task automatic test_edges();
    run_directed("edge_max_0",   16'h7FFF, 0,  16'h7FFF);
    run_directed("edge_max_15",  16'h7FFF, 15, 16'h0000);
    run_directed("edge_min_1",   16'h8000, 1,  16'hC000);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    logic [W-1:0] last;
    for (int k = 0; k < 16; k++) begin
      drive_cycle(1'b1, 16'h4000, k, k);
      e = exp_q.pop_front();
      void'(exp_w_q.pop_front());
      checks++;
      if (data_out !== e || out_valid !== 1'b1)
        $display("FAIL stream_k%0d: data_out=%h out_valid=%b required %h/1", k, data_out, out_valid, e);
      else passes++;
    end
    last = 16'h4000 >> 15;
    drive_cycle(1'b0, 16'hABCD, 1, 1);
    checks++;
    if (data_out !== last || out_valid !== 1'b0)
      $display("FAIL stream_gap: data_out=%h out_valid=%b required %h/0", data_out, out_valid, last);
    else passes++;
    drive_cycle(1'b1, 16'h4000, 4, 4);
    e = exp_q.pop_front();
    void'(exp_w_q.pop_front());
    checks++;
    if (data_out !== e || out_valid !== 1'b1)
      $display("FAIL stream_resume: data_out=%h out_valid=%b required %h/1", data_out, out_valid, e);
    else passes++;
  endtask

  task automatic test_saturate();
    logic [W-1:0] e;
    logic [W-1:0] d;
    for (int s = 16; s < 32; s++) begin
      d = (s[0]) ? 16'h8001 : 16'h7FFF;
      drive_cycle(1'b1, d, 0, s);
      void'(exp_q.pop_front());
      e = exp_w_q.pop_front();
      checks++;
      if (data_out_w !== e || out_valid_w !== 1'b1)
        $display("FAIL saturate_s%0d: data_out=%h out_valid=%b required %h/1", s, data_out_w, out_valid_w, e);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic [W-1:0] ew;
    logic [W-1:0] last;
    logic [W-1:0] last_w;
    logic         v;
    int           n;
    last   = data_out;
    last_w = data_out_w;
    n      = 0;
    while (n < 1000) begin
      v = ($urandom_range(0, 9) != 0);
      drive_cycle(v, W'($urandom_range(0, 65535)), $urandom_range(0, 15), $urandom_range(0, 31));
      if (v) begin
        e  = exp_q.pop_front();
        ew = exp_w_q.pop_front();
        last   = e;
        last_w = ew;
        n++;
      end
      checks++;
      if (data_out !== last || out_valid !== v || data_out_w !== last_w || out_valid_w !== v)
        $display("FAIL random_%0d: data_out=%h/%h out_valid=%b/%b required %h/%h valid %b",
                 n, data_out, data_out_w, out_valid, out_valid_w, last, last_w, v);
      else passes++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks         = 0;
    passes         = 0;
    rst            = 1'b1;
    in_valid       = 1'b0;
    data_in        = '0;
    shift_amount   = '0;
    shift_amount_w = '0;
    test_reset();
    test_basic();
    test_sign_fill();
    test_edges();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
